lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 No parameters; all widths SHALL come from the shared width definitions (ADDR_WIDTH=32, DATA_WIDTH=32, REG_WIDTH=5, LSU_WIDTH=4).
REQ-002 One clock, synchronous active-high reset:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_ready  out  1  controller accepts the EX instruction this cycle
- ex_pc  in  ADDR_WIDTH  instruction PC
- ex_result  in  DATA_WIDTH  ALU result; the effective address for memory ops
- ex_lsu_data  in  DATA_WIDTH  store data
- ex_lsu_op  in  LSU_WIDTH  memory operation code
- ex_rd_wr_en  in  1  destination write enable
- ex_rd_wr_addr  in  REG_WIDTH  destination register
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  ADDR_WIDTH  byte address
- data_wstrb  out  4  byte strobes
- data_wdata  out  DATA_WIDTH  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response done; data_rdata is valid
- data_rdata  in  DATA_WIDTH  load word
- wb_valid  out  1  one-cycle pulse; wb_* fields are valid
- wb_pc  out  ADDR_WIDTH  retired PC
- wb_result  out  DATA_WIDTH  load data, or ex_result passed through
- wb_rd_wr_en  out  1  register write enable
- wb_rd_wr_addr  out  REG_WIDTH  destination register
- wb_ale  out  1  misaligned-address exception, qualified by wb_valid

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-004 ex_ready SHALL be 1 only in IDLE; an instruction is accepted when ex_valid && ex_ready.
REQ-005 A non-memory op (LSU_NONE) accepted in cycle N SHALL produce wb_valid in cycle N+1 with ex fields unchanged; the FSM stays in IDLE.
REQ-006 Misalignment rule: half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
REQ-007 A misaligned op SHALL issue no bus request; it SHALL produce wb_valid=1, wb_ale=1, wb_rd_wr_en=0 in cycle N+1; the FSM stays in IDLE.
REQ-008 An aligned memory op SHALL be latched at acceptance; the FSM goes IDLE->REQ.
REQ-009 In REQ, data_req SHALL be 1 with stable addr, wr, size, wstrb and wdata until data_addr_ok; the cycle after data_addr_ok, the FSM goes REQ->WAIT.
REQ-010 data_data_ok SHALL be sampled only in WAIT.
REQ-011 On data_data_ok in WAIT, the FSM goes to IDLE and wb_valid pulses in the next cycle.
REQ-012 Minimum memory-op latency from acceptance to wb_valid SHALL be 3 cycles.
REQ-013 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-014 Store data: the byte is replicated to all 4 lanes; the half is replicated to both halves.
REQ-015 Loads SHALL select the addressed lane of data_rdata; LD_B and LD_H sign-extend, LD_BU and LD_HU zero-extend, LD_W passes the word.
REQ-016 Stores SHALL retire with wb_rd_wr_en=0.
REQ-017 Outside REQ, data_req SHALL be 0; wb_valid is a single-cycle pulse.

Reset
REQ-018 Reset SHALL force the FSM to IDLE and clear data_req, wb_valid, wb_ale and wb_rd_wr_en; all other registered outputs are cleared to 0.
REQ-019 Reset asserted in REQ or WAIT SHALL abandon the op: no wb_valid; a late data_data_ok is ignored because the FSM is in IDLE.

Structure
REQ-020 The lsu_op encoding SHALL live in the shared package lsu_pkg: LSU_NONE=0, LD_B=1, LD_H=2, LD_W=3, LD_BU=4, LD_HU=5, ST_B=6, ST_H=7, ST_W=8. The package also holds the state enum and size constants.
REQ-021 Load extraction and extension SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-022 Non-memory op (ex_result=0x1234) -> next cycle wb_valid=1, wb_result=0x1234, and data_req never asserts.
REQ-023 ST_B at addr 0x1003 with data 0xAB -> wstrb=4'b1000, wdata=0xABABABAB, size=0; addr_ok stalled 2 cycles keeps the request stable.
REQ-024 LD_H at 0x2002 with rdata=0x8001_0000 -> wb_result=0xFFFF8001; LD_HU -> wb_result=0x00008001.
REQ-025 LD_W at 0x3001 -> no data_req, wb_ale=1, wb_rd_wr_en=0, latency 1 cycle.
REQ-026 Back-to-back LD_W with addr_ok and data_ok immediate -> wb_valid every 3 cycles, and ex_ready=0 while in REQ or WAIT.
REQ-027 Reset asserted in WAIT, then data_data_ok arrives -> FSM in IDLE, wb_valid stays 0, next op accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller slice.
// Holds the datapath widths, the memory operation encoding, the controller
// state enum, bus size codes and small decode helpers used by lsu_ctrl.
package lsu_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_WIDTH  = 5;
  localparam int unsigned LSU_WIDTH  = 4;

  typedef enum logic [LSU_WIDTH-1:0] {
    LSU_NONE = 4'd0,
    LD_B     = 4'd1,
    LD_H     = 4'd2,
    LD_W     = 4'd3,
    LD_BU    = 4'd4,
    LD_HU    = 4'd5,
    ST_B     = 4'd6,
    ST_H     = 4'd7,
    ST_W     = 4'd8
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Codes 9..15 are unused and behave like LSU_NONE.
  function automatic logic is_mem_op(input logic [LSU_WIDTH-1:0] op);
    return (op >= LD_B) && (op <= ST_W);
  endfunction

  function automatic logic is_store_op(input logic [LSU_WIDTH-1:0] op);
    return (op >= ST_B) && (op <= ST_W);
  endfunction

  function automatic logic [1:0] op_size(input logic [LSU_WIDTH-1:0] op);
    case (op)
      LD_B, LD_BU, ST_B: return SIZE_B;
      LD_H, LD_HU, ST_H: return SIZE_H;
      default:           return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_H:  return lsb[0];
      SIZE_W:  return |lsb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the bus
// word and sign- or zero-extends it according to the load opcode.
//   op_i     : memory operation code
//   addr_i   : low two address bits of the access
//   rdata_i  : raw word returned by the bus
//   result_o : register write-back value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [LSU_WIDTH-1:0]  op_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result_o = {24'h0, byte_sel};
      LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the EX stage, a request/response data
// bus and write-back. Non-memory and misaligned ops retire the next cycle;
// aligned memory ops go IDLE -> REQ (hold request until data_addr_ok) ->
// WAIT (until data_data_ok) -> IDLE, retiring one cycle later.
//   clock/reset         : rising-edge clock, synchronous active-high reset
//   ex_*                : instruction handed over by EX (ex_ready = accept)
//   data_*              : data bus request and response
//   wb_*                : single-cycle retirement record (wb_ale = misaligned)
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] ex_lsu_data,
  input  logic [LSU_WIDTH-1:0]  ex_lsu_op,
  input  logic                  ex_rd_wr_en,
  input  logic [REG_WIDTH-1:0]  ex_rd_wr_addr,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [3:0]            data_wstrb,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_pc,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic                  wb_rd_wr_en,
  output logic [REG_WIDTH-1:0]  wb_rd_wr_addr,
  output logic                  wb_ale
);

  lsu_state_e state_q, state_d;

  // Op latched at acceptance; drives the bus and the eventual retirement.
  logic [LSU_WIDTH-1:0]  op_q;
  logic [ADDR_WIDTH-1:0] addr_q, pc_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            size_q;
  logic                  wr_q, rd_en_q;
  logic [REG_WIDTH-1:0]  rd_addr_q;

  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_ale_q, wb_ale_d;
  logic                  wb_rd_wr_en_q, wb_rd_wr_en_d;
  logic [ADDR_WIDTH-1:0] wb_pc_q, wb_pc_d;
  logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
  logic [REG_WIDTH-1:0]  wb_rd_wr_addr_q, wb_rd_wr_addr_d;

  logic [1:0]            ex_size;
  logic                  ex_mem, ex_mis, mem_accept;
  logic [3:0]            ex_wstrb;
  logic [DATA_WIDTH-1:0] ex_wdata, load_data;

  always_comb begin
    ex_size    = op_size(ex_lsu_op);
    ex_mem     = is_mem_op(ex_lsu_op);
    ex_mis     = ex_mem && is_misaligned(ex_size, ex_result[1:0]);
    mem_accept = (state_q == S_IDLE) && ex_valid && ex_mem && !ex_mis;
    case (ex_size)
      SIZE_B: begin
        ex_wstrb = 4'b0001 << ex_result[1:0];
        ex_wdata = {4{ex_lsu_data[7:0]}};
      end
      SIZE_H: begin
        ex_wstrb = 4'b0011 << ex_result[1:0];
        ex_wdata = {2{ex_lsu_data[15:0]}};
      end
      default: begin
        ex_wstrb = 4'b1111;
        ex_wdata = ex_lsu_data;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .op_i     (op_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (data_rdata),
    .result_o (load_data)
  );

  always_comb begin
    state_d         = state_q;
    wb_valid_d      = 1'b0;
    wb_ale_d        = wb_ale_q;
    wb_rd_wr_en_d   = wb_rd_wr_en_q;
    wb_pc_d         = wb_pc_q;
    wb_result_d     = wb_result_q;
    wb_rd_wr_addr_d = wb_rd_wr_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (ex_mem && !ex_mis) begin
            state_d = S_REQ;
          end else begin
            // Non-memory or misaligned: retire directly, no bus traffic.
            wb_valid_d      = 1'b1;
            wb_ale_d        = ex_mis;
            wb_rd_wr_en_d   = ex_rd_wr_en && !ex_mis;
            wb_pc_d         = ex_pc;
            wb_result_d     = ex_result;
            wb_rd_wr_addr_d = ex_rd_wr_addr;
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d         = S_IDLE;
          wb_valid_d      = 1'b1;
          wb_ale_d        = 1'b0;
          wb_rd_wr_en_d   = rd_en_q && !wr_q;
          wb_pc_d         = pc_q;
          wb_result_d     = wr_q ? addr_q : load_data;
          wb_rd_wr_addr_d = rd_addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wb_valid_q      <= 1'b0;
      wb_ale_q        <= 1'b0;
      wb_rd_wr_en_q   <= 1'b0;
      wb_pc_q         <= '0;
      wb_result_q     <= '0;
      wb_rd_wr_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      wb_valid_q      <= wb_valid_d;
      wb_ale_q        <= wb_ale_d;
      wb_rd_wr_en_q   <= wb_rd_wr_en_d;
      wb_pc_q         <= wb_pc_d;
      wb_result_q     <= wb_result_d;
      wb_rd_wr_addr_q <= wb_rd_wr_addr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      addr_q    <= '0;
      pc_q      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else if (mem_accept) begin
      op_q      <= ex_lsu_op;
      addr_q    <= ex_result;
      pc_q      <= ex_pc;
      wdata_q   <= ex_wdata;
      wstrb_q   <= ex_wstrb;
      size_q    <= ex_size;
      wr_q      <= is_store_op(ex_lsu_op);
      rd_en_q   <= ex_rd_wr_en;
      rd_addr_q <= ex_rd_wr_addr;
    end
  end

  assign ex_ready      = (state_q == S_IDLE);
  assign data_req      = (state_q == S_REQ);
  assign data_wr       = wr_q;
  assign data_size     = size_q;
  assign data_addr     = addr_q;
  assign data_wstrb    = wstrb_q;
  assign data_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_ale        = wb_ale_q;
  assign wb_rd_wr_en   = wb_rd_wr_en_q;
  assign wb_pc         = wb_pc_q;
  assign wb_result     = wb_result_q;
  assign wb_rd_wr_addr = wb_rd_wr_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic [31:0] ex_lsu_data;
  logic [3:0]  ex_lsu_op;
  logic        ex_rd_wr_en;
  logic [4:0]  ex_rd_wr_addr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_result;
  logic        wb_rd_wr_en;
  logic [4:0]  wb_rd_wr_addr;
  logic        wb_ale;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  lsu_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_pc         (ex_pc),
    .ex_result     (ex_result),
    .ex_lsu_data   (ex_lsu_data),
    .ex_lsu_op     (ex_lsu_op),
    .ex_rd_wr_en   (ex_rd_wr_en),
    .ex_rd_wr_addr (ex_rd_wr_addr),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wstrb    (data_wstrb),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_result     (wb_result),
    .wb_rd_wr_en   (wb_rd_wr_en),
    .wb_rd_wr_addr (wb_rd_wr_addr),
    .wb_ale        (wb_ale)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (access rules in plain arithmetic) ----
  function automatic int ref_bytes(input int op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    return 4;
  endfunction

  function automatic bit ref_is_mem(input int op);
    return op >= 1 && op <= 8;
  endfunction

  function automatic bit ref_is_store(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit ref_misaligned(input int op, input logic [31:0] a);
    return ref_is_mem(op) && ((a % ref_bytes(op)) != 0);
  endfunction

  function automatic logic [31:0] ref_size_code(input int op);
    int n = ref_bytes(op);
    return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
  endfunction

  function automatic logic [31:0] ref_strobe(input int op, input logic [31:0] a);
    int n = ref_bytes(op);
    if (n == 4) return 32'hF;
    return ((32'd1 << n) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] d);
    int n = ref_bytes(op);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh = rd >> (8 * (a % 4));
    logic [31:0] v;
    case (op)
      1: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
      4: v = sh & 32'hFF;
      2: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
      5: v = sh & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- helpers -----------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b0;
      tick();
      chk("idle_wb_valid", wb_valid, 0);
      chk("idle_data_req", data_req, 0);
      chk("idle_ex_ready", ex_ready, 1);
    end
  endtask

  // Issues one op in the current (IDLE) cycle, plays the bus with the given
  // stalls, and checks the retirement. Returns with wb_valid high.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input logic [31:0] pc,
                        input logic rd_en, input logic [4:0] rd,
                        input int astall, input int dstall, output int lat);
    int unsigned t0;
    bit mis = ref_misaligned(op, addr);
    bit mem = ref_is_mem(op);
    bit st  = ref_is_store(op);
    chk("accept_ex_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_pc = pc; ex_result = addr; ex_lsu_data = data;
    ex_lsu_op = 4'(op); ex_rd_wr_en = rd_en; ex_rd_wr_addr = rd;
    t0 = cyc;
    tick();
    // Scramble EX inputs so only latched values can reach the bus / wb.
    ex_valid = 1'b0; ex_pc = $urandom; ex_result = $urandom; ex_lsu_data = $urandom;
    ex_lsu_op = 4'($urandom_range(0, 8)); ex_rd_wr_addr = 5'($urandom);
    if (!mem || mis) begin
      chk("direct_data_req", data_req, 0);
      chk("direct_wb_ale", wb_ale, 32'(mis));
      chk("direct_wb_rd_en", wb_rd_wr_en, mis ? 32'd0 : 32'(rd_en));
    end else begin
      for (int k = 0; k <= astall; k++) begin
        chk("req_data_req", data_req, 1);
        chk("req_ex_ready", ex_ready, 0);
        chk("req_wb_valid", wb_valid, 0);
        chk("req_addr", data_addr, addr);
        chk("req_wr", data_wr, 32'(st));
        chk("req_size", data_size, ref_size_code(op));
        if (st) begin
          chk("req_wstrb", data_wstrb, ref_strobe(op, addr));
          chk("req_wdata", data_wdata, ref_wdata(op, data));
        end
        data_addr_ok = (k == astall);
        data_data_ok = (k < astall);  // must be ignored outside WAIT
        data_rdata   = $urandom;
        tick();
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      for (int k = 0; k <= dstall; k++) begin
        chk("wait_data_req", data_req, 0);
        chk("wait_ex_ready", ex_ready, 0);
        chk("wait_wb_valid", wb_valid, 0);
        data_data_ok = (k == dstall);
        data_rdata   = (k == dstall) ? rdata : $urandom;
        tick();
      end
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      chk("mem_data_req", data_req, 0);
      chk("mem_wb_ale", wb_ale, 0);
      chk("mem_wb_rd_en", wb_rd_wr_en, st ? 32'd0 : 32'(rd_en));
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_pc", wb_pc, pc);
    chk("wb_rd_addr", wb_rd_wr_addr, 32'(rd));
    if (mem && !mis && !st) chk("wb_result_load", wb_result, ref_load(op, addr, rdata));
    else                    chk("wb_result_pass", wb_result, addr);
    lat = int'(cyc - t0);
    chk("latency", lat, (mem && !mis) ? 32'(3 + astall + dstall) : 32'd1);
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int lat;
    int unsigned w0, w1, w2;
    reset = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_result = '0; ex_lsu_data = '0;
    ex_lsu_op = '0; ex_rd_wr_en = 1'b0; ex_rd_wr_addr = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) tick();
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_data_req", data_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_ale", wb_ale, 0);
    chk("rst_wb_rd_en", wb_rd_wr_en, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_data_wstrb", data_wstrb, 0);
    reset = 1'b0;
    idle(2);

    // Non-memory op passes through in one cycle.
    run_op(0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 5'd3, 0, 0, lat);
    idle(1);

    // Byte store to lane 3 with a two-cycle address stall.
    run_op(6, 32'h0000_1003, 32'h0000_00AB, 32'h0, 32'h0000_0104, 1'b1, 5'd4, 2, 0, lat);
    chk("stb_wstrb_const", ref_strobe(6, 32'h1003), 32'h8);
    idle(1);

    // Upper-half loads, signed and unsigned.
    run_op(2, 32'h0000_2002, 32'h0, 32'h8001_0000, 32'h0000_0108, 1'b1, 5'd5, 0, 1, lat);
    chk("ldh_const", wb_result, 32'hFFFF_8001);
    idle(1);
    run_op(5, 32'h0000_2002, 32'h0, 32'h8001_0000, 32'h0000_010C, 1'b1, 5'd6, 1, 0, lat);
    chk("ldhu_const", wb_result, 32'h0000_8001);
    idle(1);

    // Misaligned word load retires with an exception next cycle.
    run_op(3, 32'h0000_3001, 32'h0, 32'h0, 32'h0000_0110, 1'b1, 5'd7, 0, 0, lat);
    idle(1);

    // Back-to-back aligned word loads, immediate bus: one retire per 3 cycles.
    run_op(3, 32'h0000_4000, 32'h0, 32'h1111_2222, 32'h0000_0114, 1'b1, 5'd8, 0, 0, lat);
    w0 = cyc;
    run_op(3, 32'h0000_4004, 32'h0, 32'h3333_4444, 32'h0000_0118, 1'b1, 5'd9, 0, 0, lat);
    w1 = cyc;
    run_op(3, 32'h0000_4008, 32'h0, 32'h5555_6666, 32'h0000_011C, 1'b1, 5'd10, 0, 0, lat);
    w2 = cyc;
    chk("b2b_period_1", w1 - w0, 3);
    chk("b2b_period_2", w2 - w1, 3);
    idle(1);

    // Reset while in WAIT abandons the op; a late response is ignored.
    ex_valid = 1'b1; ex_lsu_op = 4'd3; ex_result = 32'h0000_5000; ex_pc = 32'h0000_0120;
    ex_rd_wr_en = 1'b1; ex_rd_wr_addr = 5'd11;
    tick();
    ex_valid = 1'b0;
    chk("rw_req", data_req, 1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("rw_in_wait", ex_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_after_rst_ready", ex_ready, 1);
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    tick();
    data_data_ok = 1'b0;
    chk("rw_late_ok_wb_valid", wb_valid, 0);
    chk("rw_late_ok_ready", ex_ready, 1);
    idle(2);
    run_op(1, 32'h0000_6001, 32'h0, 32'h0000_F000, 32'h0000_0124, 1'b1, 5'd12, 0, 0, lat);
    idle(1);

    // Randomized mix against the reference model.
    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 8);
      logic [31:0] a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      run_op(op, a, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), lat);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
